bcd_seq_comparator: RTL and testbench

//  Parametrised N-digit signed BCD magnitude comparator. Scans digits serially, MSD first.

---
 rtl/bcd_seq_comparator_pkg.sv | 23 ++
 rtl/bcd_seq_comparator_if.sv | 30 +++
 rtl/bcd_seq_comparator_digit_cmp.sv | 20 ++
 rtl/bcd_seq_comparator.sv | 203 ++++++++++++++++++++
 tb/tb_bcd_seq_comparator.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/bcd_seq_comparator_pkg.sv
// Shared types and helpers for the serial signed BCD magnitude comparator.
// The CMP_* codes are the magnitude result carried through the scan.
package bcd_seq_comparator_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    CMP_LT = 2'b01,
    CMP_EQ = 2'b10,
    CMP_GT = 2'b11
  } cmp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_seq_comparator_if.sv
// Request/result bundle of the BCD comparator: master drives operands and start,
// slave (the comparator) returns busy/done and the L/E/G/invalid flags.
interface bcd_seq_comparator_if #(
  parameter int NDIGITS = 3
);
  import bcd_seq_comparator_pkg::*;

  logic                       start;
  logic [BCD_W*NDIGITS-1:0]   a_digits;
  logic [BCD_W*NDIGITS-1:0]   b_digits;
  logic                       a_sign;
  logic                       b_sign;
  logic                       busy;
  logic                       done;
  logic                       L;
  logic                       E;
  logic                       G;
  logic                       invalid;

  modport master (
    output start, a_digits, b_digits, a_sign, b_sign,
    input  busy, done, L, E, G, invalid
  );

  modport slave (
    input  start, a_digits, b_digits, a_sign, b_sign,
    output busy, done, L, E, G, invalid
  );

endinterface

// File: rtl/bcd_seq_comparator_digit_cmp.sv
// Combinational compare of one BCD digit pair, producing a CMP_* code.
module bcd_digit_cmp
  import bcd_seq_comparator_pkg::*;
(
  input  logic [BCD_W-1:0] i_a,
  input  logic [BCD_W-1:0] i_b,
  output cmp_t             o_cmp
);

  always_comb begin
    if (i_a < i_b) begin
      o_cmp = CMP_LT;
    end else if (i_a > i_b) begin
      o_cmp = CMP_GT;
    end else begin
      o_cmp = CMP_EQ;
    end
  end

endmodule

// File: rtl/bcd_seq_comparator.sv
// Serial N-digit signed BCD comparator, MSD first, with early exit and invalid-digit detection.
// The MSD is compared on the start edge itself, so SCAN covers digits NDIGITS-2 down to 0.
module bcd_seq_comparator
  import bcd_seq_comparator_pkg::*;
#(
  parameter int NDIGITS    = 3,
  parameter bit SIGNED     = 1'b1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_seq_comparator_if.slave  bus
);

  localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int IDX_TOP = (NDIGITS > 1) ? NDIGITS - 2 : 0;
  localparam int MSD_LO  = (NDIGITS - 1) * BCD_W;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [BCD_W*NDIGITS-1:0]  r_a;
  logic [BCD_W*NDIGITS-1:0]  r_b;
  logic                      r_a_sign;
  logic                      r_b_sign;
  logic                      r_a_zero;
  logic                      r_b_zero;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_next;
  cmp_t                      r_mag;
  cmp_t                      w_mag_next;
  logic                      r_l;
  logic                      r_e;
  logic                      r_g;
  logic                      r_invalid;

  logic [NDIGITS-1:0]        w_a_ok;
  logic [NDIGITS-1:0]        w_b_ok;
  logic                      w_invalid_in;
  logic [BCD_W-1:0]          w_a_dig [NDIGITS];
  logic [BCD_W-1:0]          w_b_dig [NDIGITS];
  logic [BCD_W-1:0]          w_cmp_a;
  logic [BCD_W-1:0]          w_cmp_b;
  cmp_t                      w_dig_cmp;
  logic                      w_idle;
  logic                      w_start;
  logic                      w_sa;
  logic                      w_sb;
  logic                      w_za;
  logic                      w_zb;
  logic                      w_l;
  logic                      w_e;
  logic                      w_g;

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign w_a_ok[gi]  = is_bcd(bus.a_digits[gi*BCD_W +: BCD_W]);
      assign w_b_ok[gi]  = is_bcd(bus.b_digits[gi*BCD_W +: BCD_W]);
      assign w_a_dig[gi] = r_a[gi*BCD_W +: BCD_W];
      assign w_b_dig[gi] = r_b[gi*BCD_W +: BCD_W];
    end
  endgenerate

  assign w_invalid_in = ~(&w_a_ok) | ~(&w_b_ok);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_start      = w_idle & bus.start;

  // In IDLE the single digit comparator sees the live MSD; afterwards the captured digit at idx.
  assign w_cmp_a = w_idle ? bus.a_digits[MSD_LO +: BCD_W] : w_a_dig[r_idx];
  assign w_cmp_b = w_idle ? bus.b_digits[MSD_LO +: BCD_W] : w_b_dig[r_idx];

  bcd_digit_cmp u_digit_cmp (
    .i_a   (w_cmp_a),
    .i_b   (w_cmp_b),
    .o_cmp (w_dig_cmp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, index and magnitude accumulation
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_mag_next   = r_mag;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mag_next = w_dig_cmp;
          if (w_invalid_in || (NDIGITS == 1) ||
              (EARLY_EXIT && (w_dig_cmp != CMP_EQ))) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_SCAN;
            w_idx_next   = IDX_W'(IDX_TOP);
          end
        end
      end
      ST_SCAN: begin
        // Only the first differing digit decides; later digits cannot override it.
        if (r_mag == CMP_EQ) begin
          w_mag_next = w_dig_cmp;
        end
        if ((EARLY_EXIT && (w_mag_next != CMP_EQ)) || (r_idx == '0)) begin
          w_state_next = ST_DONE;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Sign resolution; signs/zero flags come straight from the bus when deciding out of IDLE.
  assign w_sa = w_idle ? bus.a_sign : r_a_sign;
  assign w_sb = w_idle ? bus.b_sign : r_b_sign;
  assign w_za = w_idle ? ~(|bus.a_digits) : r_a_zero;
  assign w_zb = w_idle ? ~(|bus.b_digits) : r_b_zero;

  always_comb begin
    w_l = 1'b0;
    w_e = 1'b0;
    w_g = 1'b0;
    if (!SIGNED || (w_sa == w_sb && !w_sa)) begin
      w_l = (w_mag_next == CMP_LT);
      w_e = (w_mag_next == CMP_EQ);
      w_g = (w_mag_next == CMP_GT);
    end else if (w_sa == w_sb) begin
      w_l = (w_mag_next == CMP_GT);
      w_e = (w_mag_next == CMP_EQ);
      w_g = (w_mag_next == CMP_LT);
    end else if (w_za && w_zb) begin
      w_e = 1'b1;
    end else begin
      w_g = ~w_sa;
      w_l = w_sa;
    end
  end

  // Datapath: operand capture, scan index, magnitude and held result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_a_sign  <= 1'b0;
      r_b_sign  <= 1'b0;
      r_a_zero  <= 1'b0;
      r_b_zero  <= 1'b0;
      r_idx     <= '0;
      r_mag     <= CMP_EQ;
      r_l       <= 1'b0;
      r_e       <= 1'b0;
      r_g       <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      if (w_start) begin
        r_a      <= bus.a_digits;
        r_b      <= bus.b_digits;
        r_a_sign <= bus.a_sign;
        r_b_sign <= bus.b_sign;
        r_a_zero <= ~(|bus.a_digits);
        r_b_zero <= ~(|bus.b_digits);
      end
      r_idx <= w_idx_next;
      r_mag <= w_mag_next;
      if (w_state_next == ST_DONE) begin
        if (w_idle && w_invalid_in) begin
          r_l       <= 1'b0;
          r_e       <= 1'b0;
          r_g       <= 1'b0;
          r_invalid <= 1'b1;
        end else begin
          r_l       <= w_l;
          r_e       <= w_e;
          r_g       <= w_g;
          r_invalid <= 1'b0;
        end
      end
    end
  end

  // Moore outputs
  always_comb begin
    bus.busy    = (r_state == ST_SCAN);
    bus.done    = (r_state == ST_DONE);
    bus.L       = r_l;
    bus.E       = r_e;
    bus.G       = r_g;
    bus.invalid = r_invalid;
  end

endmodule

// File: tb/tb_bcd_seq_comparator.sv
// Directed bench for bcd_seq_comparator: one early-exit instance and one full-scan instance.
module tb_bcd_seq_comparator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_seq_comparator_if #(.NDIGITS(3)) if_ee ();
  bcd_seq_comparator_if #(.NDIGITS(3)) if_ne ();

  bcd_seq_comparator #(.NDIGITS(3), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_ee)
  );

  bcd_seq_comparator #(.NDIGITS(3), .SIGNED(1'b1), .EARLY_EXIT(1'b0)) dut_ne (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_ne)
  );

  // Result encoding {L,E,G,invalid}
  localparam logic [3:0] R_L = 4'b1000;
  localparam logic [3:0] R_E = 4'b0100;
  localparam logic [3:0] R_G = 4'b0010;
  localparam logic [3:0] R_I = 4'b0001;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ne, input logic st, input logic [11:0] a, input logic [11:0] b,
                       input logic sa, input logic sb);
    if (ne) begin
      if_ne.start = st; if_ne.a_digits = a; if_ne.b_digits = b;
      if_ne.a_sign = sa; if_ne.b_sign = sb;
    end else begin
      if_ee.start = st; if_ee.a_digits = a; if_ee.b_digits = b;
      if_ee.a_sign = sa; if_ee.b_sign = sb;
    end
  endtask

  // {busy, done, L, E, G, invalid}
  function automatic logic [5:0] sample(input bit ne);
    if (ne)
      return {if_ne.busy, if_ne.done, if_ne.L, if_ne.E, if_ne.G, if_ne.invalid};
    return {if_ee.busy, if_ee.done, if_ee.L, if_ee.E, if_ee.G, if_ee.invalid};
  endfunction

  // Pulse start, scramble inputs afterwards, observe 6 cycles and check latency/result/hold.
  task automatic cmp(input string tag, input bit ne, input logic [11:0] a, input logic [11:0] b,
                     input logic sa, input logic sb, input bit restart,
                     input int exp_lat, input logic [3:0] exp_res);
    int          lat;
    int          ndone;
    bit          busy_seen;
    logic [3:0]  res;
    logic [5:0]  s;
    lat = 0; ndone = 0; busy_seen = 0; res = '0;
    @(negedge clk);
    drive(ne, 1'b1, a, b, sa, sb);
    @(posedge clk); #1;
    drive(ne, 1'b0, 12'h999, 12'h000, ~sa, ~sb);
    for (int c = 1; c <= 6; c++) begin
      s = sample(ne);
      if (s[5]) busy_seen = 1'b1;
      if (s[4]) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          res = s[3:0];
        end
      end
      if (restart && c == 1) drive(ne, 1'b1, 12'h100, 12'h900, 1'b0, 1'b0);
      if (restart && c == 2) drive(ne, 1'b0, 12'h100, 12'h900, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    s = sample(ne);
    $display("%s: a=%s%03h b=%s%03h lat=%0d dones=%0d busy_seen=%0d LEGI=%04b",
             tag, sa ? "-" : "+", a, sb ? "-" : "+", b, lat, ndone, busy_seen, res);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_busy"}, int'(busy_seen), int'(exp_lat > 1));
    check({tag, "_res"}, int'(res), int'(exp_res));
    check({tag, "_hold"}, int'(s[3:0]), int'(exp_res));
  endtask

  initial begin
    logic [5:0] s;
    int         nd;
    drive(1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ee", int'(sample(1'b0)), 0);
    check("reset_ne", int'(sample(1'b1)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    cmp("t1_gt_msd",    1'b0, 12'h826, 12'h749, 1'b0, 1'b0, 1'b0, 1, R_G);
    cmp("t2_eq",        1'b0, 12'h126, 12'h126, 1'b0, 1'b0, 1'b0, 3, R_E);
    cmp("t2_lt_lsd",    1'b0, 12'h126, 12'h129, 1'b0, 1'b0, 1'b0, 3, R_L);
    cmp("t2_lt_mid",    1'b0, 12'h126, 12'h146, 1'b0, 1'b0, 1'b0, 2, R_L);
    cmp("t3_neg_swap",  1'b0, 12'h126, 12'h749, 1'b1, 1'b1, 1'b0, 1, R_G);
    cmp("t3_neg_swap2", 1'b0, 12'h749, 12'h126, 1'b1, 1'b1, 1'b0, 1, R_L);
    cmp("t3_pos_neg",   1'b0, 12'h001, 12'h500, 1'b0, 1'b1, 1'b0, 1, R_G);
    cmp("t3_neg_pos",   1'b0, 12'h900, 12'h001, 1'b1, 1'b0, 1'b0, 1, R_L);
    cmp("t3_zero",      1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 3, R_E);
    cmp("t4_inv_a",     1'b0, 12'h1A6, 12'h749, 1'b0, 1'b0, 1'b0, 1, R_I);
    cmp("t4_clear",     1'b0, 12'h826, 12'h749, 1'b0, 1'b0, 1'b0, 1, R_G);
    cmp("t4_inv_b",     1'b0, 12'h749, 12'h12F, 1'b0, 1'b0, 1'b0, 1, R_I);
    cmp("t5_full_scan", 1'b1, 12'h826, 12'h749, 1'b0, 1'b0, 1'b1, 3, R_G);
    cmp("t5_prev",      1'b0, 12'h500, 12'h499, 1'b0, 1'b0, 1'b0, 1, R_G);

    // Reset asserted in the second cycle of a three-cycle scan
    @(negedge clk);
    drive(1'b0, 1'b1, 12'h126, 12'h129, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'h126, 12'h129, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("t6_busy_before", int'(sample(1'b0) >> 5), 1);
    rst_n = 1'b0;
    #1;
    s = sample(1'b0);
    $display("t6_reset: busy/done/LEGI=%06b", s);
    check("t6_cleared", int'(s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (sample(1'b0) & 6'b010000) nd++;
    end
    check("t6_no_done", nd, 0);
    cmp("t6_after", 1'b0, 12'h500, 12'h050, 1'b0, 1'b0, 1'b0, 1, R_G);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
